// File: rtl/cordic_vectoring_core_if.sv
// Request/result bundle for the CORDIC vectoring engine.
// Master drives start and operands; slave returns magnitude and angle.
interface cordic_vectoring_core_if #(
  parameter int NUM_WIDTH = 16,
  parameter int ANG_WIDTH = 16
);
  logic                        start;
  logic signed [NUM_WIDTH-1:0] x_in;
  logic signed [NUM_WIDTH-1:0] y_in;
  logic [NUM_WIDTH+1:0]        mag;
  logic signed [ANG_WIDTH-1:0] angle;
  logic                        busy;
  logic                        done;

  modport master (
    output start, x_in, y_in,
    input  mag, angle, busy, done
  );

  modport slave (
    input  start, x_in, y_in,
    output mag, angle, busy, done
  );
endinterface

// File: rtl/cordic_vectoring_core.sv
// Iterative vectoring-mode CORDIC: magnitude and atan2(y, x) in Q3.12.
// Define CORDIC_GAIN_COMP_EN to add a 1/K gain-compensation step.
module cordic_vectoring_core #(
  parameter int NUM_WIDTH = 16,
  parameter int ITER      = 12,
  parameter int ANG_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  cordic_vectoring_core_if.slave bus
);
  localparam int W = NUM_WIDTH + 2;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic signed [ANG_WIDTH-1:0] HALF_PI =
    ANG_WIDTH'(6434);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_COMP,
    S_FIN
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] xs, ys;
  logic signed [ANG_WIDTH-1:0] z_q, z_d;
  logic signed [ANG_WIDTH-1:0] ang_q, ang_d;
  logic [W-1:0] mag_q, mag_d;
`ifdef CORDIC_GAIN_COMP_EN
  logic signed [W-1:0] xc;
`endif

  function automatic logic signed [ANG_WIDTH-1:0] atan_lut(
    input logic [3:0] i
  );
    logic [11:0] r;
    case (i)
      4'd0:    r = 12'd3217;
      4'd1:    r = 12'd1899;
      4'd2:    r = 12'd1003;
      4'd3:    r = 12'd509;
      4'd4:    r = 12'd256;
      4'd5:    r = 12'd128;
      4'd6:    r = 12'd64;
      4'd7:    r = 12'd32;
      4'd8:    r = 12'd16;
      4'd9:    r = 12'd8;
      4'd10:   r = 12'd4;
      4'd11:   r = 12'd2;
      default: r = 12'd0;
    endcase
    return ANG_WIDTH'(r);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    xs      = x_q >>> cnt_q;
    ys      = y_q >>> cnt_q;
`ifdef CORDIC_GAIN_COMP_EN
    xc = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6)
       - (x_q >>> 9) - (x_q >>> 13);
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = {{2{bus.x_in[NUM_WIDTH-1]}}, bus.x_in};
          y_d     = {{2{bus.y_in[NUM_WIDTH-1]}}, bus.y_in};
          z_d     = '0;
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        // Fold the left half-plane into the right; widened
        // datapath keeps -(-2^(N-1)) representable.
        if (x_q[W-1]) begin
          if (!y_q[W-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = HALF_PI;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -HALF_PI;
          end
        end
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!y_q[W-1]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_lut(cnt_q);
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_lut(cnt_q);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          // Results land with the FIN entry so done
          // and valid data share the same cycle.
          mag_d   = $unsigned(x_d);
          ang_d   = z_d;
          state_d = S_FIN;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        x_d     = xc;
        mag_d   = $unsigned(xc);
        ang_d   = z_q;
        state_d = S_FIN;
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy  = (state_q == S_PRE)
                  || (state_q == S_ITER)
                  || (state_q == S_COMP);
  assign bus.done  = (state_q == S_FIN);
  assign bus.mag   = mag_q;
  assign bus.angle = ang_q;
endmodule
